tri_feeder: RTL
===============

# tri_feeder

Triangle source for the rasterizer. Once per frame, walks a mesh stored in two external synchronous-read memories: an index buffer of triangles and a vertex buffer of screen-space vertices. It assembles each triangle into three vertex words and presents them on a valid/ready handshake. After the last triangle it pulses `obj_done`. Sits between the vertex/transform memory and the rasterizer's `vert1/vert2/vert3/valid_tri/obj_done` inputs.

## Interface
- `NUM_TRIS`, 12: triangles in the mesh; index-buffer depth.
- `NUM_VERTS`, 8: vertex-buffer depth.
- `TIDX_W`, `$clog2(NUM_TRIS)`: index-buffer address width.
- `VIDX_W`, `$clog2(NUM_VERTS)`: vertex index width.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `new_frame`  in  1  start pulse; walk the mesh once.
- `idx_addr`  out  TIDX_W  index-buffer read address.
- `idx_data`  in  3*VIDX_W  `{i3,i2,i1}`; valid 2 cycles after the address.
- `vtx_addr`  out  VIDX_W  vertex-buffer read address.
- `vtx_data`  in  27  `{x[8:0],y[8:0],z[8:0]}`; valid 2 cycles after the address.
- `vert1`, `vert2`, `vert3`  out  [8:0] [2:0]  triangle vertices; element [2]=x, [1]=y, [0]=z.
- `valid_tri`  out  1  triangle presented.
- `rast_ready`  in  1  rasterizer accepts the triangle.
- `obj_done`  out  1  one-cycle pulse; mesh complete.
- `busy`  out  1  high from start until `obj_done`.
- `overrun`  out  1  one-cycle pulse; `new_frame` arrived while busy.

## Operation
- FSM states: IDLE, IDX, IDX_WAIT, VTX, VTX_WAIT, CULL (present only with the macro), SEND, DONE.
- **IDLE**
  - On `new_frame`, clear the triangle counter `tri_cnt`, set `busy`, and go to IDX.
- **IDX**
  - `idx_addr` = `tri_cnt`.
  - Go to IDX_WAIT.
- **IDX_WAIT**
  - Lasts 2 cycles.
  - On the second cycle, register `idx_data` into i1/i2/i3.
  - Go to VTX.
- **VTX**
  - Lasts 3 consecutive cycles.
  - Drives `vtx_addr` = i1, then i2, then i3.
- **VTX_WAIT**
  - `vtx_data` is captured into vert1, vert2 and vert3 in turn, each 2 cycles after its address.
  - After the vert3 capture, go to CULL or SEND.
- **SEND**
  - Assert `valid_tri`; `vert1`–`vert3` stay stable.
  - Leave only on the cycle where `valid_tri && rast_ready`.
  - On leaving, deassert `valid_tri`.
  - If `tri_cnt == NUM_TRIS-1`, go to DONE; else increment `tri_cnt` and go to IDX.
- **DONE**
  - Pulse `obj_done` for 1 cycle, clear `busy`, return to IDLE.
- Handshake rules:
  - `valid_tri` never drops without acceptance.
  - `rast_ready` while `valid_tri` is low is ignored.
  - `rast_ready` may stall indefinitely.
- `new_frame` outside IDLE:
  - Ignored; pulse `overrun` on the same-cycle +1.
  - The walk in progress continues.
- `new_frame` in the same cycle as DONE: treated as overrun; IDLE is re-entered afterwards.
- Vertex index ≥ `NUM_VERTS`: the address is still issued as-is; the data is whatever memory returns (out of contract).
- Reset, including mid-walk:
  - All outputs go to 0: `vert*`, `valid_tri`, `obj_done`, `busy`, `overrun`, `idx_addr`, `vtx_addr`.
  - FSM returns to IDLE; `tri_cnt` = 0.
  - No `obj_done` is emitted for the aborted walk.

## Timing
- Let C be the cycle IDX is entered; C = 1 cycle after `new_frame` is sampled, or 1 cycle after the previous acceptance.
  - `idx_addr` is valid in C.
  - `idx_data` is captured at C+2.
  - `vtx_addr` is driven in C+3, C+4, C+5.
  - Vertices are captured at C+5, C+6, C+7.
  - `valid_tri` rises at C+8 (C+9 with culling).
- Minimum cost is 9 cycles per triangle with `rast_ready` tied high (10 with culling).
- `obj_done` is asserted the cycle after the final acceptance; `busy` falls in that same cycle.
- All outputs are registered; no combinational path from `rast_ready` to any output.

## Configuration
- `TRI_FEEDER_BACKFACE_CULL_EN`
  - Defined:
    - Adds the CULL state, 1 cycle.
    - Computes signed `A = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1)` with 10-bit signed operands and a 21-bit signed product/sum.
    - If A ≤ 0 (clockwise or degenerate), SEND is skipped: the triangle is never presented.
    - A skipped triangle advances `tri_cnt` exactly as an acceptance would, including reaching DONE if it is the last one.
  - Undefined: no CULL state; every triangle is presented.

## Test plan
- Basic walk:
  - Stimulus: `NUM_TRIS`=2, `rast_ready`=1; tri0 = indices {0,1,2}, verts (10,10,5), (50,10,5), (10,50,5).
  - Response: `valid_tri` at C+8 with `vert1` = {10,10,5}; two acceptances; `obj_done` pulses once, 1 cycle after the 2nd acceptance.
- Backpressure:
  - Stimulus: hold `rast_ready`=0 for 20 cycles during SEND.
  - Response: `valid_tri` stays high with `vert*` unchanged; accepted on the first `rast_ready`=1 cycle.
- Overrun:
  - Stimulus: `new_frame` at C+3.
  - Response: `overrun` pulses; the walk completes normally; exactly one `obj_done`.
- Reset mid-walk:
  - Stimulus: `rst_in` while in SEND.
  - Response: all outputs 0 next cycle; no `obj_done`; a later `new_frame` restarts at `tri_cnt`=0.
- Culling (macro defined):
  - Stimulus: tri with verts (10,10), (10,50), (50,10) (A<0), followed by a CCW tri.
  - Response: only the CCW tri is presented, at C+9; `obj_done` still fires.
- Last triangle culled (macro defined):
  - Stimulus: final triangle has A = 0.
  - Response: `obj_done` pulses without a final `valid_tri`.

Source files
------------

// File: rtl/tri_feeder.sv
// rtl/tri_feeder.sv - walks an indexed mesh once per frame and presents assembled triangles
// Optional feature: define TRI_FEEDER_BACKFACE_CULL_EN to drop clockwise/degenerate triangles.
module tri_feeder #(
  parameter int NUM_TRIS  = 12,
  parameter int NUM_VERTS = 8,
  parameter int TIDX_W    = $clog2(NUM_TRIS),
  parameter int VIDX_W    = $clog2(NUM_VERTS)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                new_frame,
  output logic [TIDX_W-1:0]   idx_addr,
  input  logic [3*VIDX_W-1:0] idx_data,
  output logic [VIDX_W-1:0]   vtx_addr,
  input  logic [26:0]         vtx_data,
  output logic [2:0][8:0]     vert1,
  output logic [2:0][8:0]     vert2,
  output logic [2:0][8:0]     vert3,
  output logic                valid_tri,
  input  logic                rast_ready,
  output logic                obj_done,
  output logic                busy,
  output logic                overrun
);

`ifdef TRI_FEEDER_BACKFACE_CULL_EN
  typedef enum logic [2:0] {
    S_IDLE, S_IDX, S_IDX_WAIT, S_VTX, S_VTX_WAIT, S_CULL, S_SEND, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_IDX, S_IDX_WAIT, S_VTX, S_VTX_WAIT, S_SEND, S_DONE
  } state_t;
`endif

  state_t            state, next_state;
  logic [1:0]        sub;       // cycle index within multi-cycle states
  logic [TIDX_W-1:0] tri_cnt;
  logic [VIDX_W-1:0] i2, i3;    // i1 goes straight to vtx_addr when idx_data lands
  logic              last_tri;
  logic              advance;   // moving on to the next triangle of this walk

  assign last_tri = (tri_cnt == TIDX_W'(NUM_TRIS - 1));

`ifdef TRI_FEEDER_BACKFACE_CULL_EN
  logic signed [20:0] dx21, dy31, dy21, dx31, area;
  logic               keep_tri;

  // Signed twice-area of the captured triangle; positive means counter-clockwise
  always_comb begin
    dx21     = 21'($signed({1'b0, vert2[2]}) - $signed({1'b0, vert1[2]}));
    dy31     = 21'($signed({1'b0, vert3[1]}) - $signed({1'b0, vert1[1]}));
    dy21     = 21'($signed({1'b0, vert2[1]}) - $signed({1'b0, vert1[1]}));
    dx31     = 21'($signed({1'b0, vert3[2]}) - $signed({1'b0, vert1[2]}));
    area     = (dx21 * dy31) - (dy21 * dx31);
    keep_tri = (area > 21'sd0);
  end
`endif

  // Walk sequencing: next state and the triangle-advance strobe
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      S_IDLE:     if (new_frame) next_state = S_IDX;
      S_IDX:      next_state = S_IDX_WAIT;
      S_IDX_WAIT: if (sub == 2'd1) next_state = S_VTX;
      S_VTX:      if (sub == 2'd2) next_state = S_VTX_WAIT;
`ifdef TRI_FEEDER_BACKFACE_CULL_EN
      S_VTX_WAIT: if (sub == 2'd1) next_state = S_CULL;
      S_CULL: begin
        if (keep_tri) begin
          next_state = S_SEND;
        end else if (last_tri) begin
          next_state = S_DONE;
        end else begin
          next_state = S_IDX;
          advance    = 1'b1;
        end
      end
`else
      S_VTX_WAIT: if (sub == 2'd1) next_state = S_SEND;
`endif
      S_SEND: begin
        if (valid_tri && rast_ready) begin
          if (last_tri) begin
            next_state = S_DONE;
          end else begin
            next_state = S_IDX;
            advance    = 1'b1;
          end
        end
      end
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // State register; sub restarts at 0 on every state change
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      sub   <= 2'd0;
    end else begin
      state <= next_state;
      sub   <= (next_state != state) ? 2'd0 : sub + 2'd1;
    end
  end

  // Registered outputs, memory addressing and vertex capture
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tri_cnt   <= '0;
      idx_addr  <= '0;
      vtx_addr  <= '0;
      i2        <= '0;
      i3        <= '0;
      vert1     <= '0;
      vert2     <= '0;
      vert3     <= '0;
      valid_tri <= 1'b0;
      obj_done  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun   <= new_frame && (state != S_IDLE);
      valid_tri <= (next_state == S_SEND);
      obj_done  <= (next_state == S_DONE);
      busy      <= (next_state != S_IDLE) && (next_state != S_DONE);

      if (state == S_IDLE && new_frame) begin
        tri_cnt <= '0;
      end else if (advance) begin
        tri_cnt <= tri_cnt + TIDX_W'(1);
      end

      if (next_state == S_IDX) begin
        idx_addr <= (state == S_IDLE) ? '0 : tri_cnt + TIDX_W'(1);
      end

      case (state)
        S_IDX_WAIT: begin
          if (sub == 2'd1) begin
            vtx_addr <= idx_data[VIDX_W-1:0];
            i2       <= idx_data[2*VIDX_W-1:VIDX_W];
            i3       <= idx_data[3*VIDX_W-1:2*VIDX_W];
          end
        end
        S_VTX: begin
          case (sub)
            2'd0:    vtx_addr <= i2;
            2'd1:    vtx_addr <= i3;
            2'd2:    vert1    <= vtx_data;
            default: ;
          endcase
        end
        S_VTX_WAIT: begin
          if (sub == 2'd0) vert2 <= vtx_data;
          else             vert3 <= vtx_data;
        end
        default: ;
      endcase
    end
  end

endmodule
